addsub_sat_pipe: RTL
====================

ADDSUB_SAT_PIPE -- requirements
Module: addsub_sat_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, meaning operand/result width in bits (legal 4..32).
REQ-002 SHALL provide parameter CNT_W, default 8, meaning overflow event counter width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand set presented.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a, b  input  WIDTH each  signed two's-complement operands.
REQ-008 sub  input  1  0 = a+b, 1 = a-b; sampled with operands.
REQ-009 sat_en  input  1  1 = saturate on overflow, 0 = wrap; sampled with operands.
REQ-010 out_valid  output  1  result held.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 result  output  WIDTH  signed result.
REQ-013 ovp, ovn  output  1 each  positive/negative overflow of the current result, qualified by out_valid.
REQ-014 ovp_sticky, ovn_sticky  output  1 each  latched overflow flags.
REQ-015 clr_flags  input  1  clears sticky flags and counter.
REQ-016 ovf_count  output  CNT_W  count of overflowed results delivered.

Function
REQ-017 Transfer in occurs on in_valid&in_ready; transfer out occurs on out_valid&out_ready.
REQ-018 Two-stage pipeline: S1 registers a, b, sub, sat_en; S2 registers result and flags; latency = 2 cycles from input transfer to out_valid with no stall.
REQ-019 A stage SHALL advance when it is empty or the next stage advances in the same cycle; in_ready = !S1_valid | S1 advancing (combinational from out_ready allowed).
REQ-020 Throughput SHALL be one transfer per cycle while out_ready=1; with out_ready=0 the block holds at most two transactions and in_ready deasserts once both stages are full.
REQ-021 result, ovp, ovn SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 Arithmetic SHALL be evaluated exactly at WIDTH+1 bits (sign-extended a ± sign-extended b); no separate complement-then-add at WIDTH bits.
REQ-023 ovp = exact result > 2^(WIDTH-1)-1; ovn = exact result < -2^(WIDTH-1); never both.
REQ-024 b = -2^(WIDTH-1) with sub=1 SHALL be handled exactly (e.g. 0 - min gives ovp=1).
REQ-025 sat_en=0: result = low WIDTH bits of exact result; sat_en=1: result = max positive on ovp, min negative on ovn, exact otherwise.
REQ-026 ovp_sticky/ovn_sticky SHALL set on an output transfer carrying ovp/ovn and hold until clr_flags or rst.
REQ-027 ovf_count SHALL increment by 1 on each output transfer with ovp|ovn, saturating at 2^CNT_W-1 (no wrap).
REQ-028 clr_flags coincident with an overflowed output transfer: the new event wins; sticky = that flag, ovf_count = 1.
REQ-029 clr_flags SHALL NOT affect pipeline contents or handshake.

Reset
REQ-030 On rst=1 at a clock edge: S1/S2 valid cleared, out_valid=0, result=0, ovp=ovn=0, sticky flags=0, ovf_count=0; in-flight transactions discarded.
REQ-031 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-032 rst SHALL take priority over all other inputs, including simultaneous transfers and clr_flags.

Verification (WIDTH=16)
REQ-033 add a=0x7FFF b=0x0001: sat_en=0 -> result 0x8000 ovp=1 two cycles later; sat_en=1 -> 0x7FFF ovp=1; ovp_sticky=1, ovf_count increments once per transfer.
REQ-034 sub a=0x0000 b=0x8000 -> ovp=1, result 0x8000 (wrap) / 0x7FFF (sat); sub a=0x8000 b=0x0001 -> ovn=1, result 0x7FFF (wrap) / 0x8000 (sat).
REQ-035 back-to-back 4 transactions with out_ready=0 for 3 cycles -> in_ready low after 2 held, all 4 results delivered in order, unchanged while stalled, none lost or duplicated.
REQ-036 256 overflowed transfers with CNT_W=8 -> ovf_count sticks at 0xFF; clr_flags together with an overflowed transfer -> ovf_count=1, sticky set.
REQ-037 rst asserted with both stages full and out_ready=0 -> next cycle out_valid=0, all flags/count 0, in_ready=1; subsequent 0x0003-0x0005 -> result 0xFFFE, ovp=ovn=0.

Source files
------------

// File: rtl/addsub_sat_pipe_if.sv
`default_nettype none
// ============================================================================
// Module  : addsub_sat_pipe_if
// Brief   : Operand/result handshake bundle for the saturating add/sub pipe.
// Revision: 1.0 - initial release
// ============================================================================
interface addsub_sat_pipe_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             sat_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             ovp;
  logic             ovn;
  logic             ovp_sticky;
  logic             ovn_sticky;
  logic             clr_flags;
  logic [CNT_W-1:0] ovf_count;

  modport master (
    output in_valid, a, b, sub, sat_en, out_ready, clr_flags,
    input  in_ready, out_valid, result, ovp, ovn, ovp_sticky, ovn_sticky, ovf_count
  );

  modport slave (
    input  in_valid, a, b, sub, sat_en, out_ready, clr_flags,
    output in_ready, out_valid, result, ovp, ovn, ovp_sticky, ovn_sticky, ovf_count
  );
endinterface
`default_nettype wire

// File: rtl/addsub_sat_pipe.sv
`default_nettype none
// ============================================================================
// Module  : addsub_sat_pipe
// Brief   : Two-stage valid/ready signed add/sub with optional saturation,
//           overflow flags, sticky flags and a saturating overflow counter.
// Revision: 1.0 - initial release
// ============================================================================
module addsub_sat_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  addsub_sat_pipe_if.slave  bus
);

  localparam logic [WIDTH-1:0] c_max_pos = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s1_sub;
  logic             r_s1_sat;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_ovp;
  logic             r_ovn;
  logic             r_ovp_sticky;
  logic             r_ovn_sticky;
  logic [CNT_W-1:0] r_cnt;

  logic             w_s2_adv;
  logic             w_in_ready;
  logic [WIDTH:0]   w_a_ext;
  logic [WIDTH:0]   w_b_ext;
  logic [WIDTH:0]   w_exact;
  logic             w_ovp;
  logic             w_ovn;
  logic [WIDTH-1:0] w_res;
  logic             w_out_xfer;
  logic             w_ev_p;
  logic             w_ev_n;

  assign w_s2_adv   = !r_s2_valid || bus.out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_adv;

  // One extra bit holds every sum/difference exactly, including 0 - min.
  assign w_a_ext = {r_s1_a[WIDTH-1], r_s1_a};
  assign w_b_ext = {r_s1_b[WIDTH-1], r_s1_b};
  assign w_exact = r_s1_sub ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);
  assign w_ovp   = !w_exact[WIDTH] &&  w_exact[WIDTH-1];
  assign w_ovn   =  w_exact[WIDTH] && !w_exact[WIDTH-1];

  always_comb begin
    w_res = w_exact[WIDTH-1:0];
    if (r_s1_sat && w_ovp) begin
      w_res = c_max_pos;
    end else if (r_s1_sat && w_ovn) begin
      w_res = c_min_neg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_sub   <= 1'b0;
      r_s1_sat   <= 1'b0;
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_ovp      <= 1'b0;
      r_ovn      <= 1'b0;
    end else begin
      if (w_in_ready) begin
        r_s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          r_s1_a   <= bus.a;
          r_s1_b   <= bus.b;
          r_s1_sub <= bus.sub;
          r_s1_sat <= bus.sat_en;
        end
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_result <= w_res;
          r_ovp    <= w_ovp;
          r_ovn    <= w_ovn;
        end
      end
    end
  end

  assign w_out_xfer = r_s2_valid && bus.out_ready;
  assign w_ev_p     = w_out_xfer && r_ovp;
  assign w_ev_n     = w_out_xfer && r_ovn;

  // A clear coinciding with an overflowed delivery keeps that new event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovp_sticky <= 1'b0;
      r_ovn_sticky <= 1'b0;
      r_cnt        <= '0;
    end else if (bus.clr_flags) begin
      r_ovp_sticky <= w_ev_p;
      r_ovn_sticky <= w_ev_n;
      r_cnt        <= (w_ev_p || w_ev_n) ? c_cnt_one : '0;
    end else begin
      if (w_ev_p) r_ovp_sticky <= 1'b1;
      if (w_ev_n) r_ovn_sticky <= 1'b1;
      if ((w_ev_p || w_ev_n) && (r_cnt != c_cnt_max)) begin
        r_cnt <= r_cnt + c_cnt_one;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_s2_valid;
  assign bus.result     = r_result;
  assign bus.ovp        = r_s2_valid && r_ovp;
  assign bus.ovn        = r_s2_valid && r_ovn;
  assign bus.ovp_sticky = r_ovp_sticky;
  assign bus.ovn_sticky = r_ovn_sticky;
  assign bus.ovf_count  = r_cnt;

endmodule
`default_nettype wire
